peripheral_logic_agree_debounce: RTL and testbench

//  Debounce/qualify stage that consumes the four taps of the logic delay chain.
//  An input level is accepted only when all four taps agree and stay in agreement for HOLD_CYCLES further edges.

---
 rtl/peripheral_logic_pkg.sv | 9 +
 rtl/peripheral_logic_sat_counter.sv | 27 ++
 rtl/peripheral_logic_agree_debounce.sv | 142 ++++++++++++++
 tb/tb_peripheral_logic_agree_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/peripheral_logic_pkg.sv
// Shared types for the peripheral logic delay-chain qualifier.
package peripheral_logic_pkg;
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } deb_state_t;
endpackage

// File: rtl/peripheral_logic_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module peripheral_logic_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/peripheral_logic_agree_debounce.sv
// Qualifies the four delay-chain taps into a debounced level with edge pulses
// and saturating rise/glitch event counters.
module peripheral_logic_agree_debounce
  import peripheral_logic_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             data_delay_1,
  input  logic             data_delay_2,
  input  logic             data_delay_3,
  input  logic             data_delay_4,
  input  logic             clear_counts,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] glitch_count
);
  localparam int HW = (HOLD_CYCLES >= 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] ONE_H    = HW'(1);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("HOLD_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("CNT_W must be >= 1");
    end
  endgenerate

  logic       w_agree_hi, w_agree_lo;
  deb_state_t r_state, w_state_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic       r_level, w_level_nxt;
  logic       r_rise, w_rise_nxt;
  logic       r_fall, w_fall_nxt;
  logic       w_rise_inc, w_glitch_inc;

  assign w_agree_hi = data_delay_1 & data_delay_2 & data_delay_3 & data_delay_4;
  assign w_agree_lo = ~(data_delay_1 | data_delay_2 | data_delay_3 | data_delay_4);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= STABLE_LO;
      r_hold  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Any loss of agreement during qualification, including opposite agreement, aborts.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_level_nxt  = r_level;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_rise_inc   = 1'b0;
    w_glitch_inc = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        w_hold_nxt = '0;
        if (w_agree_hi) begin
          w_state_nxt = QUAL_HI;
          w_hold_nxt  = ONE_H;
        end
      end
      QUAL_HI: begin
        if (!w_agree_hi) begin
          w_state_nxt  = STABLE_LO;
          w_hold_nxt   = '0;
          w_glitch_inc = 1'b1;
        end else if (r_hold == HOLD_MAX) begin
          w_state_nxt = STABLE_HI;
          w_hold_nxt  = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
          w_rise_inc  = 1'b1;
        end else begin
          w_hold_nxt = r_hold + ONE_H;
        end
      end
      STABLE_HI: begin
        w_hold_nxt = '0;
        if (w_agree_lo) begin
          w_state_nxt = QUAL_LO;
          w_hold_nxt  = ONE_H;
        end
      end
      QUAL_LO: begin
        if (!w_agree_lo) begin
          w_state_nxt  = STABLE_HI;
          w_hold_nxt   = '0;
          w_glitch_inc = 1'b1;
        end else if (r_hold == HOLD_MAX) begin
          w_state_nxt = STABLE_LO;
          w_hold_nxt  = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_hold_nxt = r_hold + ONE_H;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_hold_nxt  = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  peripheral_logic_sat_counter #(.W(CNT_W)) u_rise_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (w_rise_inc),
    .clr    (clear_counts),
    .count  (rise_count)
  );

  peripheral_logic_sat_counter #(.W(CNT_W)) u_glitch_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (w_glitch_inc),
    .clr    (clear_counts),
    .count  (glitch_count)
  );

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
endmodule

// File: tb/tb_peripheral_logic_agree_debounce.sv
// Directed bench for the delay-chain qualifier: vector table plus reset and saturation sequences.
module tb_peripheral_logic_agree_debounce;
  logic        clock;
  logic        resetn;
  logic [3:0]  taps, taps2;
  logic        clr, clr2;
  logic        level, rise, fall;
  logic [15:0] rcnt, gcnt;
  logic        level2, rise2, fall2;
  logic [1:0]  rcnt2, gcnt2;

  int checks   = 0;
  int failures = 0;

  peripheral_logic_agree_debounce #(.HOLD_CYCLES(3), .CNT_W(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .data_delay_1 (taps[3]),
    .data_delay_2 (taps[2]),
    .data_delay_3 (taps[1]),
    .data_delay_4 (taps[0]),
    .clear_counts (clr),
    .level_out    (level),
    .rise_pulse   (rise),
    .fall_pulse   (fall),
    .rise_count   (rcnt),
    .glitch_count (gcnt)
  );

  peripheral_logic_agree_debounce #(.HOLD_CYCLES(3), .CNT_W(2)) dut2 (
    .clock        (clock),
    .resetn       (resetn),
    .data_delay_1 (taps2[3]),
    .data_delay_2 (taps2[2]),
    .data_delay_3 (taps2[1]),
    .data_delay_4 (taps2[0]),
    .clear_counts (clr2),
    .level_out    (level2),
    .rise_pulse   (rise2),
    .fall_pulse   (fall2),
    .rise_count   (rcnt2),
    .glitch_count (gcnt2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  taps;
    logic        clr;
    logic        level;
    logic        rise;
    logic        fall;
    logic [15:0] rcnt;
    logic [15:0] gcnt;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] t, input logic c);
    taps = t;
    clr  = c;
    @(posedge clock);
    #1;
  endtask

  task automatic step2(input logic [3:0] t, input logic c);
    taps2 = t;
    clr2  = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //           taps    clr   lvl   rise  fall  rcnt gcnt
    vecs[0]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
    vecs[3]  = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
    vecs[4]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
    vecs[5]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
    vecs[6]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
    vecs[7]  = '{4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1};
    vecs[8]  = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[9]  = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[10] = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[11] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[12] = '{4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[13] = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[14] = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[15] = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[16] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd2};
    vecs[17] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[18] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[19] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[20] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[21] = '{4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0};

    resetn = 1'b0;
    taps   = 4'hF;
    taps2  = 4'h0;
    clr    = 1'b0;
    clr2   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_level", 32'(level), 32'd0);
    check("reset_rise",  32'(rise),  32'd0);
    check("reset_fall",  32'(fall),  32'd0);
    check("reset_rcnt",  32'(rcnt),  32'd0);
    check("reset_gcnt",  32'(gcnt),  32'd0);
    taps = 4'h0;
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].taps, vecs[i].clr);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].level));
      check($sformatf("vec%0d_rise",  i), 32'(rise),  32'(vecs[i].rise));
      check($sformatf("vec%0d_fall",  i), 32'(fall),  32'(vecs[i].fall));
      check($sformatf("vec%0d_rcnt",  i), 32'(rcnt),  32'(vecs[i].rcnt));
      check($sformatf("vec%0d_gcnt",  i), 32'(gcnt),  32'(vecs[i].gcnt));
    end

    // Fall back to low, then stop mid-qualification with hold_cnt=2.
    repeat (4) step(4'h0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd0);
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    check("pre_rst_rcnt", 32'(rcnt), 32'd1);
    resetn = 1'b0;
    #2;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_rcnt",  32'(rcnt),  32'd0);
    check("async_rst_rise",  32'(rise),  32'd0);
    @(negedge clock);
    resetn = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step(4'hF, 1'b0);
      check($sformatf("requal_e%0d_level", e), 32'(level), 32'd0);
    end
    step(4'hF, 1'b0);
    check("requal_e3_level", 32'(level), 32'd1);
    check("requal_e3_rise",  32'(rise),  32'd1);
    check("requal_e3_rcnt",  32'(rcnt),  32'd1);

    // Narrow counter saturation and clear-wins-over-increment.
    for (int k = 1; k <= 5; k++) begin
      repeat (4) step2(4'hF, 1'b0);
      check($sformatf("sat_rise%0d_level", k), 32'(level2), 32'd1);
      check($sformatf("sat_rise%0d_rcnt", k), 32'(rcnt2), (k < 3) ? 32'(k) : 32'd3);
      repeat (4) step2(4'h0, 1'b0);
      check($sformatf("sat_fall%0d_rcnt", k), 32'(rcnt2), (k < 3) ? 32'(k) : 32'd3);
    end
    repeat (3) step2(4'hF, 1'b0);
    step2(4'hF, 1'b1);
    check("clr_win_rcnt",  32'(rcnt2),  32'd0);
    check("clr_win_rise",  32'(rise2),  32'd1);
    check("clr_win_level", 32'(level2), 32'd1);
    step2(4'hF, 1'b0);
    check("clr_after_rise", 32'(rise2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
